// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: pipelined binary adder tree, one level per cycle, with backpressure and flush.
// Define ADDER_TREE_SAT_EN to saturate the final sum to WIDTH bits.
module adder_tree_pipe #(
    parameter int N_IN  = 4,
    parameter int WIDTH = 8,
    localparam int LVL  = $clog2(N_IN),
`ifdef ADDER_TREE_SAT_EN
    localparam int OW   = WIDTH,
`else
    localparam int OW   = WIDTH + LVL,
`endif
    localparam int OCW  = $clog2(LVL) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [OW-1:0]         out_sum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OCW-1:0]        occupancy
);
    if (N_IN < 2 || N_IN > 16 || (N_IN & (N_IN - 1)) != 0) begin : g_bad_n
        $error("adder_tree_pipe: N_IN must be a power of two in 2..16");
    end
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_w
        $error("adder_tree_pipe: WIDTH must be in 2..32");
    end

    logic [LVL-1:0]         vld_q, vld_d;
    logic                   stall;
    logic [WIDTH+LVL-1:0]   full_sum;

    assign stall     = vld_q[LVL-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld_q[LVL-1];
    assign occupancy = OCW'($countones(vld_q));

    // Bit 0 is level 1; a stall freezes bubbles as well as items.
    always_comb begin
        vld_d = flush ? '0 : stall ? vld_q : LVL'({vld_q, in_valid});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_q <= '0;
        else      vld_q <= vld_d;
    end

    for (genvar k = 1; k <= LVL; k++) begin : g_lvl
        localparam int W = WIDTH + k;
        localparam int M = N_IN >> k;
        logic [2*M*(W-1)-1:0] src;
        logic [M*W-1:0]       sum_d, sum_q;
        if (k == 1) begin : g_src0
            assign src = in_data;
        end else begin : g_srcn
            assign src = g_lvl[k-1].sum_q;
        end
        always_comb begin
            sum_d = '0;
            for (int j = 0; j < M; j++)
                sum_d[j*W +: W] = W'(src[2*j*(W-1) +: W-1]) + W'(src[(2*j+1)*(W-1) +: W-1]);
        end
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)        sum_q <= '0;
            else if (!stall) sum_q <= sum_d;
        end
        if (k == LVL) begin : g_last
            assign full_sum = sum_q;
        end
    end

`ifdef ADDER_TREE_SAT_EN
    assign out_sum = |full_sum[WIDTH+LVL-1:WIDTH] ? {OW{1'b1}} : full_sum[OW-1:0];
`else
    assign out_sum = full_sum;
`endif
endmodule
